// File: rtl/cla_pkg.sv
// ----------------------------------------------------------------------------
// cla_pkg
// Shared types for the clause switch / arbiter slice.
//   cla_t     : one clause word as carried from producers to the clause queue
//   CLA_W     : width of cla_t in bits
//   ch_idx_t  : channel index, wide enough for the largest supported switch
// ----------------------------------------------------------------------------
package cla_pkg;

  // A clause word: literal payload plus an end-of-clause marker.
  typedef struct packed {
    logic        eoc;
    logic [14:0] lit;
  } cla_t;

  localparam int CLA_W   = $bits(cla_t);
  localparam int MAX_NCH = 16;

  typedef logic [$clog2(MAX_NCH)-1:0] ch_idx_t;

endpackage

// File: rtl/cla_sw_fifo.sv
// ----------------------------------------------------------------------------
// cla_sw_fifo
// Single-channel synchronous FIFO feeding the clause switch arbiter.
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset (empties the FIFO)
//   push       write push_data at the rising edge
//   push_data  word to write
//   pop        drop the head word at the rising edge
//   head       current head word (valid when !empty)
//   full       DEPTH words stored
//   empty      no word stored
// Pointers carry one extra wrap bit so full and empty differ only in the MSB.
// ----------------------------------------------------------------------------
module cla_sw_fifo
  import cla_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = CLA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage is plain data: no reset needed, only the pointers decide validity.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= push_data;
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/cla_sw_arb.sv
// ----------------------------------------------------------------------------
// cla_sw_arb
// N-channel clause switch: per-channel FIFOs, an arbiter and one registered
// output stage toward the clause queue (clq). Channel 0 is the carb producer,
// channels 1..NCH-1 are engine/aux producers.
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   in_data    NCH clause words, channel i at [i*DATA_W +: DATA_W]
//   in_valid   word valid per channel
//   in_stall   channel FIFO full; producer must hold
//   out_data   clause word to clq
//   out_valid  out_data valid
//   out_ready  clq accepts this cycle
//   out_src    channel index of out_data
//   ovf_err    sticky per channel: push attempted while stalled
//   grant_cnt  (only with CLA_SW_STATS_EN) NCH saturating 16-bit counters of
//              output handshakes per source channel
// Optional feature macro: CLA_SW_STATS_EN
// ----------------------------------------------------------------------------
module cla_sw_arb
  import cla_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int DEPTH    = 4,
  parameter int DATA_W   = CLA_W,
  parameter int PRIO_CH0 = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH*DATA_W-1:0]   in_data,
  input  logic [NCH-1:0]          in_valid,
  output logic [NCH-1:0]          in_stall,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(NCH)-1:0]  out_src,
  output logic [NCH-1:0]          ovf_err
`ifdef CLA_SW_STATS_EN
  ,
  output logic [NCH*16-1:0]       grant_cnt
`endif
);

  localparam int SRC_W = $clog2(NCH);

  logic [NCH-1:0]    full;
  logic [NCH-1:0]    empty;
  logic [NCH-1:0]    push;
  logic [NCH-1:0]    pop_p0;
  logic [DATA_W-1:0] head_p0 [NCH];

  logic              any_req_p0;
  logic [SRC_W-1:0]  grant_p0;
  logic [SRC_W-1:0]  cand_p0;
  logic              load_en;
  logic [SRC_W-1:0]  rr_ptr;

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [SRC_W-1:0]  src_p1;

  // Stage p0: per-channel FIFOs and arbitration over their heads
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign push[g] = in_valid[g] & ~full[g];

    cla_sw_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[g]),
      .push_data (in_data[g*DATA_W +: DATA_W]),
      .pop       (pop_p0[g]),
      .head      (head_p0[g]),
      .full      (full[g]),
      .empty     (empty[g])
    );
  end

  // Stall comes from the registered fill level only, so a pop in the same
  // cycle never lifts it.
  assign in_stall = full;

  assign load_en = ~vld_p1 | out_ready;

  // Round-robin search begins one past the last grant. In priority mode a
  // nonempty channel 0 wins outright and is skipped by the round-robin scan.
  always_comb begin
    any_req_p0 = 1'b0;
    grant_p0   = '0;
    cand_p0    = '0;
    if (PRIO_CH0 != 0 && !empty[0]) begin
      any_req_p0 = 1'b1;
      grant_p0   = '0;
    end else begin
      for (int k = 1; k <= NCH; k++) begin
        cand_p0 = SRC_W'((int'(rr_ptr) + k) % NCH);
        if (!any_req_p0 && !empty[cand_p0] &&
            !(PRIO_CH0 != 0 && cand_p0 == '0)) begin
          any_req_p0 = 1'b1;
          grant_p0   = cand_p0;
        end
      end
    end
  end

  always_comb begin
    pop_p0 = '0;
    if (load_en && any_req_p0) pop_p0[grant_p0] = 1'b1;
  end

  // Stage p1: output register toward clq
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      src_p1  <= '0;
      rr_ptr  <= '0;
    end else if (load_en) begin
      vld_p1 <= any_req_p0;
      if (any_req_p0) begin
        data_p1 <= head_p0[grant_p0];
        src_p1  <= grant_p0;
        // Channel 0 grants under strict priority leave the rotation untouched.
        if (PRIO_CH0 == 0 || grant_p0 != '0) rr_ptr <= grant_p0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_err <= '0;
    else      ovf_err <= ovf_err | (in_valid & full);
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_src   = src_p1;

`ifdef CLA_SW_STATS_EN
  logic [15:0] gcnt [NCH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) gcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (vld_p1 && out_ready && src_p1 == SRC_W'(i) && gcnt[i] != 16'hFFFF)
          gcnt[i] <= gcnt[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_cnt
    assign grant_cnt[g*16 +: 16] = gcnt[g];
  end
`endif

endmodule
